cpu_trace_checker: RTL and testbench

//  Streaming character parser/checker for CPU commit-trace lines, one char per accepted beat.

---
 rtl/cpu_trace_checker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cpu_trace_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker
//   Streaming parser/checker for CPU commit-trace lines of the form
//     ^TIME@PC: ($GRF | *ADDR) <= DATA#
//   with optional runs of spaces around the register/memory field and the "<=" token.
//   One character is consumed per clock when char_valid is high. Each '#' that ends a line
//   produces a one-cycle report; syntactically valid lines are counted, as are valid lines
//   that carry at least one range/alignment error.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   char_valid   qualifies char; nothing advances while low
//   char         ASCII character
//   freq         clock frequency, sampled when '#' is consumed
//   format_type  0 none/invalid, 1 register write, 2 memory write (one cycle)
//   error_code   [0] time, [1] pc, [2] addr, [3] grf; zero unless format_type != 0
//   line_done    one-cycle strobe after a line-ending '#'
//   valid_cnt    saturating count of valid lines
//   err_cnt      saturating count of valid lines with a non-zero error_code

module cpu_trace_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned GRF_DIGITS  = 4,
    parameter int unsigned GRF_NUM     = 32,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int unsigned FREQ_W      = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              char_valid,
    input  logic [7:0]        char,
    input  logic [FREQ_W-1:0] freq,
    output logic [1:0]        format_type,
    output logic [3:0]        error_code,
    output logic              line_done,
    output logic [CNT_W-1:0]  valid_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    // Accumulators sized to hold 10**DIGITS-1, so accumulation never overflows.
    localparam int unsigned TIME_W = $clog2(10 ** TIME_DIGITS);
    localparam int unsigned GRF_W  = $clog2(10 ** GRF_DIGITS);

    typedef enum logic [3:0] {
        StIdle, StTime, StPc, StColon, StSp1, StGrf, StAddr,
        StSp2, StEq, StSp3, StData, StFail
    } state_e;

    state_e             state_q, state_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [GRF_W-1:0]   grf_q, grf_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic [7:0]         dig_cnt_q, dig_cnt_d;
    logic               is_mem_q, is_mem_d;
    logic [1:0]         format_type_q, format_type_d;
    logic [3:0]         error_code_q, error_code_d;
    logic               line_done_q, line_done_d;
    logic [CNT_W-1:0]   valid_cnt_q, valid_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Character classification
    logic       is_dec, is_hex;
    logic [3:0] nibble;

    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = 1'b1;
        nibble = 4'h0;
        if (is_dec) begin
            nibble = 4'(char - 8'h30);
        end else if ((char >= 8'h61) && (char <= 8'h66)) begin
            nibble = 4'(char - 8'h57);
        end else if ((char >= 8'h41) && (char <= 8'h46)) begin
            nibble = 4'(char - 8'h37);
        end else begin
            is_hex = 1'b0;
        end
    end

    // Error bits from the registered fields; '#' never modifies them, so they are final.
    logic [FREQ_W-1:0] f_half;
    logic [31:0]       f_div;
    logic [3:0]        err_c;

    always_comb begin
        f_half = freq >> 1;
        // Divisor forced non-zero so the mod stays defined; the f==0 case flags separately.
        f_div  = (f_half == '0) ? 32'd1 : 32'(f_half);
        err_c  = 4'b0000;
        err_c[0] = (f_half == '0) || ((32'(time_q) % f_div) != 32'd0);
        // Offset compare keeps range checks valid even when a bound is zero.
        err_c[1] = ((pc_q - PC_LO) > (PC_HI - PC_LO)) || (pc_q[1:0] != 2'b00);
        err_c[2] = is_mem_q &&
                   (((addr_q - ADDR_LO) > (ADDR_HI - ADDR_LO)) || (addr_q[1:0] != 2'b00));
        err_c[3] = !is_mem_q && (32'(grf_q) >= GRF_NUM);
    end

    always_comb begin
        state_d       = state_q;
        time_d        = time_q;
        grf_d         = grf_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        dig_cnt_d     = dig_cnt_q;
        is_mem_d      = is_mem_q;
        format_type_d = 2'd0;
        error_code_d  = 4'd0;
        line_done_d   = 1'b0;
        valid_cnt_d   = valid_cnt_q;
        err_cnt_d     = err_cnt_q;

        if (char_valid) begin
            if (char == 8'h5e) begin
                // '^' restarts parsing from any state
                state_d   = StTime;
                time_d    = '0;
                grf_d     = '0;
                pc_d      = '0;
                addr_d    = '0;
                dig_cnt_d = '0;
                is_mem_d  = 1'b0;
            end else if ((char == 8'h23) && (state_q != StIdle)) begin
                // '#' ends the line whether or not it parsed
                state_d     = StIdle;
                line_done_d = 1'b1;
                if ((state_q == StData) && (dig_cnt_q == 8'd8)) begin
                    format_type_d = is_mem_q ? 2'd2 : 2'd1;
                    error_code_d  = err_c;
                    if (valid_cnt_q != '1) begin
                        valid_cnt_d = valid_cnt_q + 1'b1;
                    end
                    if ((err_c != 4'd0) && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    StIdle: ;
                    StTime: begin
                        if (is_dec && (32'(dig_cnt_q) < TIME_DIGITS)) begin
                            time_d    = TIME_W'(32'(time_q) * 32'd10 + 32'(nibble));
                            dig_cnt_d = dig_cnt_q + 8'd1;
                        end else if ((char == 8'h40) && (dig_cnt_q != 8'd0)) begin
                            state_d   = StPc;
                            dig_cnt_d = '0;
                        end else begin
                            state_d = StFail;
                        end
                    end
                    StPc: begin
                        if (is_hex) begin
                            pc_d      = {pc_q[27:0], nibble};
                            dig_cnt_d = dig_cnt_q + 8'd1;
                            if (dig_cnt_q == 8'd7) begin
                                state_d = StColon;
                            end
                        end else begin
                            state_d = StFail;
                        end
                    end
                    StColon: state_d = (char == 8'h3a) ? StSp1 : StFail;
                    StSp1: begin
                        if (char == 8'h24) begin
                            state_d   = StGrf;
                            dig_cnt_d = '0;
                            is_mem_d  = 1'b0;
                        end else if (char == 8'h2a) begin
                            state_d   = StAddr;
                            dig_cnt_d = '0;
                            is_mem_d  = 1'b1;
                        end else if (char != 8'h20) begin
                            state_d = StFail;
                        end
                    end
                    StGrf: begin
                        if (is_dec && (32'(dig_cnt_q) < GRF_DIGITS)) begin
                            grf_d     = GRF_W'(32'(grf_q) * 32'd10 + 32'(nibble));
                            dig_cnt_d = dig_cnt_q + 8'd1;
                        end else if ((char == 8'h20) && (dig_cnt_q != 8'd0)) begin
                            state_d = StSp2;
                        end else if ((char == 8'h3c) && (dig_cnt_q != 8'd0)) begin
                            state_d = StEq;
                        end else begin
                            state_d = StFail;
                        end
                    end
                    StAddr: begin
                        if (is_hex && (dig_cnt_q < 8'd8)) begin
                            addr_d    = {addr_q[27:0], nibble};
                            dig_cnt_d = dig_cnt_q + 8'd1;
                        end else if ((char == 8'h20) && (dig_cnt_q == 8'd8)) begin
                            state_d = StSp2;
                        end else if ((char == 8'h3c) && (dig_cnt_q == 8'd8)) begin
                            state_d = StEq;
                        end else begin
                            state_d = StFail;
                        end
                    end
                    StSp2: begin
                        if (char == 8'h3c) begin
                            state_d = StEq;
                        end else if (char != 8'h20) begin
                            state_d = StFail;
                        end
                    end
                    StEq: state_d = (char == 8'h3d) ? StSp3 : StFail;
                    StSp3: begin
                        if (is_hex) begin
                            state_d   = StData;
                            dig_cnt_d = 8'd1;
                        end else if (char != 8'h20) begin
                            state_d = StFail;
                        end
                    end
                    StData: begin
                        // Data value is only length-checked, never stored
                        if (is_hex && (dig_cnt_q < 8'd8)) begin
                            dig_cnt_d = dig_cnt_q + 8'd1;
                        end else begin
                            state_d = StFail;
                        end
                    end
                    StFail: ;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            time_q        <= '0;
            grf_q         <= '0;
            pc_q          <= '0;
            addr_q        <= '0;
            dig_cnt_q     <= '0;
            is_mem_q      <= 1'b0;
            format_type_q <= 2'd0;
            error_code_q  <= 4'd0;
            line_done_q   <= 1'b0;
            valid_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            time_q        <= time_d;
            grf_q         <= grf_d;
            pc_q          <= pc_d;
            addr_q        <= addr_d;
            dig_cnt_q     <= dig_cnt_d;
            is_mem_q      <= is_mem_d;
            format_type_q <= format_type_d;
            error_code_q  <= error_code_d;
            line_done_q   <= line_done_d;
            valid_cnt_q   <= valid_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign format_type = format_type_q;
    assign error_code  = error_code_q;
    assign line_done   = line_done_q;
    assign valid_cnt   = valid_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Testbench for cpu_trace_checker: table of directed lines with hand-computed results,
// followed by hand-written sequences for restart-with-gaps, back-to-back lines and reset.

module tb_cpu_trace_checker;

    logic        clk;
    logic        reset_n;
    logic        char_valid;
    logic [7:0]  char_in;
    logic [15:0] freq;
    logic [1:0]  format_type;
    logic [3:0]  error_code;
    logic        line_done;
    logic [15:0] valid_cnt;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    cpu_trace_checker dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char       (char_in),
        .freq       (freq),
        .format_type(format_type),
        .error_code (error_code),
        .line_done  (line_done),
        .valid_cnt  (valid_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       line;
        logic [15:0] freq;
        logic [1:0]  ft;
        logic [3:0]  ec;
        int          vc;
        int          ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string s, input logic [15:0] f, input logic [1:0] ft,
                           input logic [3:0] ec, input int vc, input int ecnt);
        vec_t v;
        v.line = s;
        v.freq = f;
        v.ft   = ft;
        v.ec   = ec;
        v.vc   = vc;
        v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive one character for one accepted beat; returns 1 time unit after the consuming edge.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_line(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (i != s.len() - 1) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_report(input string tag, input logic [1:0] ft, input logic [3:0] ec,
                                input int vc, input int ecnt);
        check({tag, " line_done"}, 32'(line_done), 32'd1);
        check({tag, " format_type"}, 32'(format_type), 32'(ft));
        check({tag, " error_code"}, 32'(error_code), 32'(ec));
        check({tag, " valid_cnt"}, 32'(valid_cnt), 32'(vc));
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(ecnt));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " line_done clear"}, 32'(line_done), 32'd0);
        check({tag, " format_type clear"}, 32'(format_type), 32'd0);
        check({tag, " error_code clear"}, 32'(error_code), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        freq       = 16'd0;

        add_vec("^1024@000030fb: $2 <= 89abcdef#",          16'd2048, 2'd1, 4'b0010, 1, 1);
        add_vec("^50@00003000:*00002ffc<=00000000#",         16'd100,  2'd2, 4'b0000, 2, 1);
        add_vec("^7@00005000: $40 <= 12345678#",             16'd100,  2'd1, 4'b1011, 3, 2);
        add_vec("^12345@00003000:$1<=00000000#",             16'd100,  2'd0, 4'b0000, 3, 2);
        add_vec("^8@00003004:*00003000 <=   ABCDEF01#",      16'd4,    2'd2, 4'b0100, 4, 3);
        add_vec("^0@00004ffc:$31<=00000000#",                16'd1,    2'd1, 4'b0001, 5, 4);
        add_vec("^1@000030000:$1<=00000000#",                16'd100,  2'd0, 4'b0000, 5, 4);
        add_vec("^2@00003000:$ <=00000000#",                 16'd100,  2'd0, 4'b0000, 5, 4);
        add_vec("^9999@00003000:  *00000000  <=  0000000f#", 16'd2,    2'd2, 4'b0000, 6, 4);
        add_vec("^1@00003000:$1<=0000000#",                  16'd2,    2'd0, 4'b0000, 6, 4);
        add_vec("^2@00002ffc:$9999<=00000000#",              16'd4,    2'd1, 4'b1010, 7, 5);
        add_vec("^6@00004000:*00000002<=00000000#",          16'd6,    2'd2, 4'b0100, 8, 6);

        repeat (2) @(posedge clk);
        #1;
        check("reset format_type", 32'(format_type), 32'd0);
        check("reset error_code", 32'(error_code), 32'd0);
        check("reset line_done", 32'(line_done), 32'd0);
        check("reset valid_cnt", 32'(valid_cnt), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            freq = vecs[i].freq;
            send_line(vecs[i].line, 0);
            check_report($sformatf("vec%0d", i), vecs[i].ft, vecs[i].ec, vecs[i].vc, vecs[i].ecnt);
            @(posedge clk);
            #1;
            check_quiet($sformatf("vec%0d", i));
        end

        // Mid-line restart with 3-cycle gaps between characters: only the second line counts
        freq = 16'd100;
        send_line("^12@0000^50@00003000:*00002ffc<=00000000#", 3);
        check_report("restart_gaps", 2'd2, 4'b0000, 9, 6);
        @(posedge clk);
        #1;
        check_quiet("restart_gaps");

        // Back-to-back: second '^' consumed in the cycle line_done is reported
        send_line("^2@00003000:$1<=00000000#", 0);
        check_report("b2b first", 2'd1, 4'b0001, 10, 7);
        send_line("^100@00003000:$1<=00000000#", 0);
        check_report("b2b second", 2'd1, 4'b0000, 11, 7);

        // Reset asserted in the middle of DATA
        send_line("^50@00003000:$1<=0000", 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset valid_cnt", 32'(valid_cnt), 32'd0);
        check("async reset err_cnt", 32'(err_cnt), 32'd0);
        check_quiet("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        send_line("0000#", 0);
        check("post reset stray #", 32'(line_done), 32'd0);
        send_line("^50@00003000:*00002ffc<=00000000#", 0);
        check_report("post reset line", 2'd2, 4'b0000, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
